// File: rtl/task_mem_loader_pkg.sv
// Shared GPU front-end constants for the writable task memory: instruction and
// row geometry, the flat bus type, the loader state encoding and a width helper.
package task_mem_loader_pkg;

  localparam int INSN_SIZE      = 16;
  localparam int INSN_COUNT     = 4;
  localparam int TASK_MEM_DEPTH = 2;
  localparam int TASK_MEM_WIDTH = TASK_MEM_DEPTH * INSN_COUNT * INSN_SIZE;

  localparam logic [INSN_SIZE-1:0] NOP_INSN = '0;

  typedef logic [TASK_MEM_WIDTH-1:0] task_mem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_DONE
  } load_state_t;

  // Pointer width for a given range; never below one bit.
  function automatic int ptr_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/task_mem_packer.sv
// Flattens the row/slot instruction array into the packed task-memory bus the
// cores consume: row r slot k sits at bit offset (r*INSN_COUNT+k)*INSN_SIZE.
module task_mem_packer #(
  parameter int INSN_SIZE  = task_mem_loader_pkg::INSN_SIZE,
  parameter int INSN_COUNT = task_mem_loader_pkg::INSN_COUNT,
  parameter int TM_DEPTH   = task_mem_loader_pkg::TASK_MEM_DEPTH
) (
  input  logic [INSN_SIZE-1:0]                     slots [TM_DEPTH][INSN_COUNT],
  output logic [TM_DEPTH*INSN_COUNT*INSN_SIZE-1:0] task_memory
);

  for (genvar r = 0; r < TM_DEPTH; r++) begin : g_row
    for (genvar k = 0; k < INSN_COUNT; k++) begin : g_slot
      assign task_memory[(r*INSN_COUNT+k)*INSN_SIZE +: INSN_SIZE] = slots[r][k];
    end
  end

endmodule

// File: rtl/task_mem_loader.sv
// Run-time loadable task memory: packs a valid/ready instruction stream row by
// row, NOP-pads a partial final row, flags complete rows and detects overflow.
module task_mem_loader #(
  parameter int INSN_SIZE  = task_mem_loader_pkg::INSN_SIZE,
  parameter int INSN_COUNT = task_mem_loader_pkg::INSN_COUNT,
  parameter int TM_DEPTH   = task_mem_loader_pkg::TASK_MEM_DEPTH,
  parameter logic [INSN_SIZE-1:0] NOP_INSN = INSN_SIZE'(task_mem_loader_pkg::NOP_INSN)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [INSN_SIZE-1:0]                     in_insn,
  input  logic                                     in_last,
  output logic [TM_DEPTH*INSN_COUNT*INSN_SIZE-1:0] task_memory,
  output logic [TM_DEPTH-1:0]                      row_valid,
  output logic [$clog2(TM_DEPTH*INSN_COUNT+1)-1:0] insn_count,
  output logic                                     load_done,
  output logic                                     overflow
);

  import task_mem_loader_pkg::*;

  localparam int SLOT_W = ptr_width(INSN_COUNT);
  localparam int ROW_W  = ptr_width(TM_DEPTH);
  localparam int CNT_W  = $clog2(TM_DEPTH*INSN_COUNT+1);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(INSN_COUNT-1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(TM_DEPTH-1);

  load_state_t          state;
  logic [ROW_W-1:0]     row_ptr;
  logic [SLOT_W-1:0]    slot_ptr;
  logic [INSN_SIZE-1:0] slots [TM_DEPTH][INSN_COUNT];

  logic at_row_end;
  logic at_mem_end;
  logic xfer;

  assign at_row_end = (slot_ptr == LAST_SLOT);
  assign at_mem_end = at_row_end && (row_ptr == LAST_ROW);

  // NOTE: in_ready is combinational on start so a restart never races a transfer.
  assign in_ready  = (state == ST_LOAD) && !start;
  assign xfer      = in_valid && in_ready;
  assign load_done = (state == ST_DONE);

  // NOTE: the slot array is reset too, so task_memory reads NOP_INSN out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row_ptr    <= '0;
      slot_ptr   <= '0;
      row_valid  <= '0;
      insn_count <= '0;
      overflow   <= 1'b0;
      for (int r = 0; r < TM_DEPTH; r++) begin
        for (int k = 0; k < INSN_COUNT; k++) begin
          slots[r][k] <= NOP_INSN;
        end
      end
    end else if (start) begin
      state      <= ST_LOAD;
      row_ptr    <= '0;
      slot_ptr   <= '0;
      row_valid  <= '0;
      insn_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (xfer) begin
            slots[row_ptr][slot_ptr] <= in_insn;
            insn_count               <= insn_count + CNT_W'(1);
            if (at_row_end) begin
              row_valid[row_ptr] <= 1'b1;
              slot_ptr           <= '0;
              if (row_ptr != LAST_ROW) row_ptr <= row_ptr + ROW_W'(1);
            end else begin
              slot_ptr <= slot_ptr + SLOT_W'(1);
            end
            if (in_last) begin
              state <= at_row_end ? ST_DONE : ST_PAD;
            end else if (at_mem_end) begin
              state    <= ST_DONE;
              overflow <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          slots[row_ptr][slot_ptr] <= NOP_INSN;
          if (at_row_end) begin
            row_valid[row_ptr] <= 1'b1;
            slot_ptr           <= '0;
            if (row_ptr != LAST_ROW) row_ptr <= row_ptr + ROW_W'(1);
            state <= ST_DONE;
          end else begin
            slot_ptr <= slot_ptr + SLOT_W'(1);
          end
        end
        ST_DONE: state <= ST_DONE;
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  task_mem_packer #(
    .INSN_SIZE (INSN_SIZE),
    .INSN_COUNT(INSN_COUNT),
    .TM_DEPTH  (TM_DEPTH)
  ) u_packer (
    .slots      (slots),
    .task_memory(task_memory)
  );

endmodule
